// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter : shares one RAM port between the CPU (C) and a host port (H);
//               round-robin on ties, fixed 2-cycle ACC/DONE transaction.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ack,
    output logic              c_stall,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic c_OWN_CPU  = 1'b0;
    localparam logic c_OWN_HOST = 1'b1;

    state_t            r_state;
    state_t            w_next;
    logic              r_gnt;
    logic              w_gnt_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic              w_c_cand;
    logic              w_h_cand;
    logic              w_pick;
    logic              w_acc;
    logic              w_done;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] w_own_addr;
    logic [DATA_W-1:0] w_own_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= c_OWN_CPU;
            r_last  <= c_OWN_HOST;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            if (w_acc) begin
                r_addr  <= w_own_addr;
                r_wdata <= w_own_wdata;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_gnt_nxt  = r_gnt;
        w_last_nxt = r_last;
        w_c_cand   = 1'b0;
        w_h_cand   = 1'b0;
        w_pick     = c_OWN_CPU;
        case (r_state)
            S_ACC: w_next = S_DONE;
            default: begin
                // The owner being acked in DONE sits out this decision.
                w_c_cand = c_req & ~((r_state == S_DONE) && (r_gnt == c_OWN_CPU));
                w_h_cand = h_req & ~((r_state == S_DONE) && (r_gnt == c_OWN_HOST));
                if (w_c_cand && w_h_cand) begin
                    w_pick = ~r_last;
                end else begin
                    w_pick = w_h_cand ? c_OWN_HOST : c_OWN_CPU;
                end
                if (w_c_cand || w_h_cand) begin
                    w_next     = S_ACC;
                    w_gnt_nxt  = w_pick;
                    w_last_nxt = w_pick;
                end else begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    assign w_acc       = (r_state == S_ACC);
    assign w_done      = (r_state == S_DONE);
    assign w_own_addr  = (r_gnt == c_OWN_HOST) ? h_addr  : c_addr;
    assign w_own_wdata = (r_gnt == c_OWN_HOST) ? h_wdata : c_wdata;

    assign ram_en    = w_acc;
    assign ram_we    = w_acc & ((r_gnt == c_OWN_HOST) ? h_we : c_we);
    assign ram_addr  = w_acc ? w_own_addr  : r_addr;
    assign ram_wdata = w_acc ? w_own_wdata : r_wdata;

    assign c_ack   = w_done & (r_gnt == c_OWN_CPU);
    assign h_ack   = w_done & (r_gnt == c_OWN_HOST);
    assign c_rdata = c_ack ? ram_rdata : '0;
    assign h_rdata = h_ack ? ram_rdata : '0;
    assign c_stall = c_req & ~c_ack;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter : directed self-checking bench for ram_arbiter with a small
//                  registered-read RAM model.
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, h_req, h_we;
    logic [15:0] c_addr, h_addr;
    logic [31:0] c_wdata, h_wdata;
    logic [31:0] c_rdata, h_rdata;
    logic        c_ack, c_stall, h_ack;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [256];
    int          n_chk;
    int          n_pass;

    ram_arbiter #(.ADDR_W(16), .DATA_W(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_rdata   (c_rdata),
        .c_ack     (c_ack),
        .c_stall   (c_stall),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_rdata   (h_rdata),
        .h_ack     (h_ack),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
            ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; ram_rdata = '0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        tick(); tick();
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_acks", {c_ack, h_ack}, 0);
        chk("rst_rdata", {c_rdata, h_rdata}, 0);
        rst = 1'b0;

        // 1: CPU store
        c_req = 1; c_we = 1; c_addr = 16'h0010; c_wdata = 32'hDEADBEEF;
        #1;
        chk("t1_stall_c0", c_stall, 1);
        chk("t1_en_c0", ram_en, 0);
        tick();
        chk("t1_en_c1", {ram_en, ram_we}, 2'b11);
        chk("t1_addr_c1", ram_addr, 16'h0010);
        chk("t1_wdata_c1", ram_wdata, 32'hDEADBEEF);
        chk("t1_stall_c1", {c_stall, c_ack}, 2'b10);
        tick();
        chk("t1_ack_c2", {c_ack, c_stall, ram_en}, 3'b100);
        c_req = 0;
        tick();
        chk("t1_hold_addr", {ram_en, ram_addr}, {1'b0, 16'h0010});

        // 2: CPU load back
        c_req = 1; c_we = 0; c_wdata = 32'h0;
        tick();
        chk("t2_acc", {ram_en, ram_we}, 2'b10);
        tick();
        chk("t2_ack", c_ack, 1);
        chk("t2_rdata", c_rdata, 32'hDEADBEEF);
        c_req = 0;
        tick();

        // 3: simultaneous requests just after reset
        rst = 1; tick(); rst = 0;
        c_req = 1; c_we = 0; c_addr = 16'h0010;
        h_req = 1; h_we = 1; h_addr = 16'h0020; h_wdata = 32'h00001234;
        tick();
        chk("t3_acc1_addr", ram_addr, 16'h0010);
        tick();
        chk("t3_ack_t2", {c_ack, h_ack}, 2'b10);
        chk("t3_rdata_c", c_rdata, 32'hDEADBEEF);
        c_req = 0;
        tick();
        chk("t3_acc2", {ram_en, ram_we, ram_addr}, {2'b11, 16'h0020});
        tick();
        chk("t3_ack_t4", {c_ack, h_ack}, 2'b01);
        h_req = 0;
        tick();

        // 4: both held for 8 transactions, last = H so C leads
        c_req = 1; c_we = 0; c_addr = 16'h0010;
        h_req = 1; h_we = 0; h_addr = 16'h0020;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("t4_acc_%0d", k), {ram_en, c_ack, h_ack, ram_addr},
                {3'b100, (k % 2 == 0) ? 16'h0010 : 16'h0020});
            tick();
            chk($sformatf("t4_done_%0d", k), {ram_en, c_ack, h_ack},
                (k % 2 == 0) ? 3'b010 : 3'b001);
        end
        c_req = 0; h_req = 0;
        tick();

        // 5: host uploads 1..4, then CPU reads them back
        for (int i = 0; i < 4; i++) begin
            h_req = 1; h_we = 1; h_addr = 16'(i); h_wdata = 32'(i + 1);
            tick();
            tick();
            chk($sformatf("t5_hack_%0d", i), {h_ack, c_ack}, 2'b10);
            h_req = 0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            c_req = 1; c_we = 0; c_addr = 16'(i);
            tick();
            tick();
            chk($sformatf("t5_cread_%0d", i), {c_ack, c_rdata}, {1'b1, 32'(i + 1)});
            c_req = 0;
            tick();
        end

        // 6: reset during ACC, pending CPU served first afterwards
        c_req = 1; c_we = 1; c_addr = 16'h0030; c_wdata = 32'hCAFEF00D;
        h_req = 1; h_we = 0; h_addr = 16'h0001;
        tick();
        chk("t6_in_acc", ram_en, 1);
        rst = 1;
        #1;
        chk("t6_rst_out", {ram_en, ram_we, ram_addr, ram_wdata, c_ack, h_ack}, '0);
        tick();
        chk("t6_rst_noack", {c_ack, h_ack}, 2'b00);
        rst = 0;
        tick();
        chk("t6_cpu_first", {ram_en, ram_addr}, {1'b1, 16'h0030});
        tick();
        chk("t6_cpu_ack", {c_ack, h_ack}, 2'b10);
        c_req = 0;
        tick();
        tick();
        chk("t6_host_ack", {c_ack, h_ack, h_rdata}, {2'b01, 32'h00000002});
        h_req = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
